seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a multi-digit common-anode 7-segment display. It holds a DIGITS-nibble display value and steps through the digit positions. For each position it presents the nibble to the registered seg7 encoder, waits a blanking interval, then enables that digit's anode for a fixed dwell. New display values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg7_scan_ctrl_if.sv | 22 ++
 rtl/seg7_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: load port and scan outputs of the 7-segment scan controller.
// master = load source / display driver side, slave = scan controller.
interface seg7_scan_ctrl_if #(
   parameter int DIGITS = 8
);
   logic                  load;
   logic [4*DIGITS-1:0]   load_data;
   logic                  pending;
   logic [3:0]            dig_num;
   logic [DIGITS-1:0]     dig_sel;
   logic                  frame_done;

   modport master (
      output load, load_data,
      input  pending, dig_num, dig_sel, frame_done
   );

   modport slave (
      input  load, load_data,
      output pending, dig_num, dig_sel, frame_done
   );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-segment scan controller with a
// double-buffered display value; SEG7_SCAN_LZB_EN enables leading-zero blanking.
module seg7_scan_ctrl #(
   parameter int DIGITS = 8,
   parameter int DWELL  = 50000,
   parameter int BLANK  = 16
) (
   input logic             clk,
   input logic             rst,
   seg7_scan_ctrl_if.slave bus
);
   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int VW   = 4 * DIGITS;

   typedef enum logic {
      S_BLANK,
      S_SHOW
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [VW-1:0]     active_q, active_d;
   logic [VW-1:0]     pend_q, pend_d;
   logic              pending_q, pending_d;
   logic [3:0]        num_q, num_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic              frame_done;
   logic              lit;

`ifdef SEG7_SCAN_LZB_EN
   // A digit is dark when it and every more significant nibble are zero.
   function automatic logic lz_dark(input logic [VW-1:0] v,
                                    input logic [IW-1:0] i);
      logic dark;
      dark = (i != '0);
      for (int k = 0; k < DIGITS; k++) begin
         if (k >= int'(i) && v[4*k +: 4] != 4'h0) dark = 1'b0;
      end
      return dark;
   endfunction

   assign lit = !lz_dark(active_d, idx_d);
`else
   assign lit = 1'b1;
`endif

   // State, counters, buffers and registered display outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_BLANK;
         idx_q     <= '0;
         cnt_q     <= '0;
         active_q  <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
         num_q     <= 4'h0;
         sel_q     <= '1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         pend_q    <= pend_d;
         pending_q <= pending_d;
         num_q     <= num_d;
         sel_q     <= sel_d;
      end
   end

   // Blank/show sequencing, digit advance, frame-boundary commit, load capture.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      active_d   = active_q;
      pend_d     = pend_q;
      pending_d  = pending_q;
      frame_done = 1'b0;
      unique case (state_q)
         S_BLANK: begin
            if (cnt_q == CW'(BLANK - 1)) begin
               cnt_d   = '0;
               state_d = S_SHOW;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SHOW: begin
            if (cnt_q == CW'(DWELL - 1)) begin
               cnt_d   = '0;
               state_d = S_BLANK;
               if (idx_q == IW'(DIGITS - 1)) begin
                  idx_d      = '0;
                  frame_done = 1'b1;
                  if (pending_q) begin
                     active_d  = pend_q;
                     pending_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
      // A load on the commit edge re-arms pending with the new data.
      if (bus.load) begin
         pend_d    = bus.load_data;
         pending_d = 1'b1;
      end
   end

   // Output values for the next cycle, so dig_num is valid as BLANK starts.
   always_comb begin
      num_d = active_d[{idx_d, 2'b00} +: 4];
      sel_d = '1;
      if (state_d == S_SHOW && lit) sel_d[idx_d] = 1'b0;
   end

   assign bus.pending    = pending_q;
   assign bus.dig_num    = num_q;
   assign bus.dig_sel    = sel_q;
   assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl (DIGITS=4, DWELL=4,
// BLANK=2); expectations follow SEG7_SCAN_LZB_EN when defined.
module tb_seg7_scan_ctrl;
   localparam int DIGITS = 4;
   localparam int DWELL  = 4;
   localparam int BLANK  = 2;
   localparam int SLOT   = BLANK + DWELL;
   localparam int FRAME  = DIGITS * SLOT;

   typedef struct {
      int         ph;
      logic [3:0] num;
      logic [3:0] sel;
   } vec_t;

   logic clk;
   logic rst;

   seg7_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

   seg7_scan_ctrl #(
      .DIGITS(DIGITS),
      .DWELL (DWELL),
      .BLANK (BLANK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks;
   int          errors;
   int          e;
   logic [15:0] m_act;
   logic [15:0] m_pend;
   logic        m_pending;
   logic [15:0] seen;
   logic [3:0]  litm;
   vec_t        tbl [8];

`ifdef SEG7_SCAN_LZB_EN
   localparam logic [3:0] LIT_0050 = 4'b0011;
   localparam logic [3:0] LIT_0000 = 4'b0001;
`else
   localparam logic [3:0] LIT_0050 = 4'b1111;
   localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s e=%0d got %0h want %0h", name, e, act, exp);
      end
   endtask

   task automatic observe();
      int ph;
      int d;
      ph = e % FRAME;
      d  = ph / SLOT;
      if (ph % SLOT == 0) seen[4*d +: 4] = bus.dig_num;
      for (int k = 0; k < DIGITS; k++) begin
         if (bus.dig_sel[k] == 1'b0) litm[k] = 1'b1;
      end
   endtask

   // Expected outputs derived from elapsed edges since reset release.
   task automatic check_outputs();
      int         ph;
      int         d;
      int         w;
      logic [3:0] es;
      logic       on;
      ph = e % FRAME;
      d  = ph / SLOT;
      w  = ph % SLOT;
      es = 4'hF;
      on = (w >= BLANK);
`ifdef SEG7_SCAN_LZB_EN
      if (d > 0 && (m_act >> (4 * d)) == 16'h0) on = 1'b0;
`endif
      if (on) es[d] = 1'b0;
      chk("dig_num", 32'(bus.dig_num), 32'(m_act[4*d +: 4]));
      chk("dig_sel", 32'(bus.dig_sel), 32'(es));
      chk("pending", 32'(bus.pending), 32'(m_pending));
      chk("frame_done", 32'(bus.frame_done), 32'(ph == FRAME - 1));
   endtask

   task automatic step(input logic ld, input logic [15:0] d);
      int ph;
      bus.load      = ld;
      bus.load_data = d;
      ph = e % FRAME;
      @(posedge clk);
      if (ph == FRAME - 1 && m_pending) begin
         m_act     = m_pend;
         m_pending = 1'b0;
      end
      if (ld) begin
         m_pend    = d;
         m_pending = 1'b1;
      end
      e++;
      #1;
      bus.load = 1'b0;
      check_outputs();
      observe();
   endtask

   task automatic advance_to(input int ph);
      while (e % FRAME != ph) step(1'b0, 16'h0);
   endtask

   task automatic capture_frame();
      seen = 16'h0;
      litm = 4'h0;
      observe();
      repeat (FRAME - 1) step(1'b0, 16'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog e=%0d", e);
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{0,  4'h4, 4'b1111};
      tbl[1] = '{2,  4'h4, 4'b1110};
      tbl[2] = '{6,  4'h3, 4'b1111};
      tbl[3] = '{8,  4'h3, 4'b1101};
      tbl[4] = '{12, 4'h2, 4'b1111};
      tbl[5] = '{14, 4'h2, 4'b1011};
      tbl[6] = '{18, 4'h1, 4'b1111};
      tbl[7] = '{20, 4'h1, 4'b0111};

      checks        = 0;
      errors        = 0;
      e             = 0;
      m_act         = 16'h0;
      m_pend        = 16'h0;
      m_pending     = 1'b0;
      seen          = 16'h0;
      litm          = 4'h0;
      rst           = 1'b0;
      bus.load      = 1'b0;
      bus.load_data = 16'h0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", 32'(bus.dig_sel), 32'hF);
      chk("rst_num", 32'(bus.dig_num), 32'h0);
      chk("rst_pending", 32'(bus.pending), 32'h0);
      chk("rst_fd", 32'(bus.frame_done), 32'h0);
      #2 rst = 1'b1;

      step(1'b1, 16'h1234);
      advance_to(0);
      for (int i = 0; i < 8; i++) begin
         advance_to(tbl[i].ph);
         chk("tbl_num", 32'(bus.dig_num), 32'(tbl[i].num));
         chk("tbl_sel", 32'(bus.dig_sel), 32'(tbl[i].sel));
      end
      advance_to(0);

      advance_to(8);
      step(1'b1, 16'hABCD);
      chk("pend_set", 32'(bus.pending), 32'h1);
      advance_to(16);
      step(1'b1, 16'h5678);
      advance_to(0);
      chk("pend_clr", 32'(bus.pending), 32'h0);
      capture_frame();
      chk("frame_5678", 32'(seen), 32'h5678);
      advance_to(0);

      advance_to(4);
      step(1'b1, 16'h9ABC);
      advance_to(FRAME - 1);
      chk("fd_hi", 32'(bus.frame_done), 32'h1);
      step(1'b1, 16'h0050);
      chk("pend_keep", 32'(bus.pending), 32'h1);
      capture_frame();
      chk("frame_9abc", 32'(seen), 32'h9ABC);
      advance_to(0);
      chk("pend_late", 32'(bus.pending), 32'h0);
      capture_frame();
      chk("frame_0050", 32'(seen), 32'h0050);
      chk("lit_0050", 32'(litm), 32'(LIT_0050));

      advance_to(0);
      step(1'b1, 16'h0000);
      advance_to(0);
      capture_frame();
      chk("frame_0000", 32'(seen), 32'h0000);
      chk("lit_0000", 32'(litm), 32'(LIT_0000));

      repeat (600) begin
         step($urandom_range(15) == 0, 16'($urandom));
      end

      step(1'b1, 16'h4321);
      advance_to(0);
      advance_to(15);
      step(1'b1, 16'h1111);
      chk("pre_rst_sel", 32'(bus.dig_sel), 32'b1011);
      #2 rst = 1'b0;
      #1;
      chk("arst_sel", 32'(bus.dig_sel), 32'hF);
      chk("arst_num", 32'(bus.dig_num), 32'h0);
      chk("arst_pending", 32'(bus.pending), 32'h0);
      e         = 0;
      m_act     = 16'h0;
      m_pend    = 16'h0;
      m_pending = 1'b0;
      #4 rst = 1'b1;
      repeat (2) step(1'b0, 16'h0);
      chk("resume_sel", 32'(bus.dig_sel), 32'b1110);
      chk("resume_num", 32'(bus.dig_num), 32'h0);
      repeat (28) step(1'b0, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
